// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - byte-bus arbiter: 4-beat opcode fetch bursts vs single-beat data accesses
module mem_port_arbiter #(
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        a_rst,
    input  logic        f_req,
    input  logic [15:0] f_pc,
    input  logic        f_flush,
    output logic [31:0] f_opcode,
    output logic        f_rdy,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [15:0] d_addr,
    input  logic [7:0]  d_wdata,
    output logic [7:0]  d_rdata,
    output logic        d_rdy,
    output logic        m_req,
    output logic        m_we,
    output logic [15:0] m_addr,
    output logic [7:0]  m_wdata,
    input  logic [7:0]  m_rdata,
    input  logic        m_ack
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [1:0]  state;
    logic [1:0]  beat;
    logic [3:0]  starve_cnt;
    logic [15:0] pc_lat;
    logic        abort;

    logic eff_f;
    logic eff_d;
    logic grant_d;
    logic grant_f;
    logic burst_end;

    // A requester still holding req during its own rdy cycle is finished, not asking again.
    assign eff_f     = f_req & ~f_rdy;
    assign eff_d     = d_req & ~d_rdy;
    assign grant_d   = eff_d & (~eff_f | (starve_cnt < STARVE_LIM));
    assign grant_f   = ~grant_d & eff_f & ~f_flush;
    assign burst_end = (beat == 2'd3) | abort | f_flush;

    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            state      <= S_IDLE;
            beat       <= 2'd0;
            starve_cnt <= 4'd0;
            pc_lat     <= 16'd0;
            abort      <= 1'b0;
            m_req      <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= 16'd0;
            m_wdata    <= 8'd0;
            f_rdy      <= 1'b0;
            d_rdy      <= 1'b0;
            f_opcode   <= 32'd0;
            d_rdata    <= 8'd0;
        end else begin
            f_rdy <= 1'b0;
            d_rdy <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_d) begin
                        state   <= S_DATA;
                        m_req   <= 1'b1;
                        m_we    <= d_we;
                        m_addr  <= d_addr;
                        m_wdata <= d_wdata;
                        if (f_req && starve_cnt != 4'hF) begin
                            starve_cnt <= starve_cnt + 4'd1;
                        end
                    end else if (grant_f) begin
                        state      <= S_FETCH;
                        m_req      <= 1'b1;
                        m_we       <= 1'b0;
                        m_addr     <= f_pc;
                        pc_lat     <= f_pc;
                        beat       <= 2'd0;
                        starve_cnt <= 4'd0;
                        abort      <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (m_ack) begin
                        f_opcode[{beat, 3'b000} +: 8] <= m_rdata;
                        if (burst_end) begin
                            // A flush never cuts a beat short; it only stops the burst after it.
                            state <= S_IDLE;
                            m_req <= 1'b0;
                            f_rdy <= ~abort & ~f_flush;
                            beat  <= 2'd0;
                            abort <= 1'b0;
                        end else begin
                            beat   <= beat + 2'd1;
                            m_addr <= pc_lat + {14'd0, beat} + 16'd1;
                        end
                    end else if (f_flush) begin
                        abort <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (m_ack) begin
                        state <= S_IDLE;
                        m_req <= 1'b0;
                        d_rdy <= 1'b1;
                        if (!m_we) begin
                            d_rdata <= m_rdata;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    m_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
